// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier driver and the multiplier it controls.
//   state_e : driver FSM states
//   func_e  : multiplier function-select codes placed on the func bus
//   func_for: function code the driver presents in a given state
package mult_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StLoadM,
    StLoadQ,
    StStart,
    StWaitLo,
    StWaitHi,
    StTurn,
    StReadLo,
    StReadHi,
    StFinish
  } state_e;

  typedef enum logic [1:0] {
    FuncLoadM  = 2'b00,
    FuncLoadQ  = 2'b01,
    FuncReadLo = 2'b10,
    FuncReadHi = 2'b11
  } func_e;

  // Only the two load states may present a load code; everything else parks on a read
  // code so the multiplier never latches a floating bus.
  function automatic func_e func_for(state_e s);
    func_e f;
    f = FuncReadLo;
    case (s)
      StLoadM:  f = FuncLoadM;
      StLoadQ:  f = FuncLoadQ;
      StReadHi: f = FuncReadHi;
      default:  f = FuncReadLo;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level.
//   clock : destination clock
//   reset : asynchronous active-low reset, forces both flops to ResetVal
//   d     : asynchronous input
//   q     : synchronised output, two clock cycles of latency
module sync2 #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q <= ResetVal;
      q      <= ResetVal;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/mult_driver.sv
// Sequencer that feeds two operands to an external bus-based multiplier and reads back the
// 2n-bit product in two halves over the same shared data bus.
//   clock   : rising-edge system clock
//   reset   : asynchronous active-low reset
//   req     : single-cycle request, accepted only when idle
//   a, b    : operands, sampled on an accepted req
//   busy    : high while a transaction is in flight
//   done    : one-cycle completion pulse (success or timeout)
//   err     : timeout flag, valid with done
//   product : {high, low} result, held until the next accepted req
//   func    : multiplier function select
//   oe      : multiplier output enable
//   start   : multiplier start, held for HOLD cycles
//   ready   : multiplier ready, asynchronous
//   data    : shared bidirectional bus
module mult_driver
  import mult_pkg::*;
#(
  parameter int unsigned n       = 8,
  parameter int unsigned HOLD    = 1200000,
  parameter int unsigned TIMEOUT = 2**24 - 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           req,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [2*n-1:0] product,
  output logic [1:0]     func,
  output logic           oe,
  output logic           start,
  input  logic           ready,
  inout  logic [n-1:0]   data
);

  localparam int unsigned CntMax = (HOLD > TIMEOUT) ? HOLD : TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [n-1:0]    b_q, b_d;
  logic [n-1:0]    data_out_q, data_out_d;
  logic            drive_q, drive_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            start_q, start_d;
  logic            oe_q, oe_d;
  logic [1:0]      func_q, func_d;
  logic [2*n-1:0]  product_q, product_d;
  logic            ready_s;
  logic            timeout_hit;
  logic            last_read_cycle;

  sync2 #(
    .ResetVal(1'b0)
  ) u_ready_sync (
    .clock(clock),
    .reset(reset),
    .d    (ready),
    .q    (ready_s)
  );

  // Read states last two cycles; the bus is sampled at the end of the second one.
  assign last_read_cycle = (cnt_q == CntW'(1));

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      StIdle:  if (req) state_d = StLoadM;
      StLoadM: state_d = StLoadQ;
      StLoadQ: state_d = StStart;
      StStart: if (cnt_q == CntW'(HOLD - 1)) state_d = StWaitLo;
      StWaitLo: begin
        if (!ready_s) begin
          state_d = StWaitHi;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d     = StFinish;
          timeout_hit = 1'b1;
        end
      end
      StWaitHi: begin
        if (ready_s) begin
          state_d = StTurn;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d     = StFinish;
          timeout_hit = 1'b1;
        end
      end
      StTurn:   state_d = StReadLo;
      StReadLo: if (last_read_cycle) state_d = StReadHi;
      StReadHi: if (last_read_cycle) state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with the state
  // they belong to.
  always_comb begin
    cnt_d      = cnt_q + CntW'(1);
    b_d        = b_q;
    data_out_d = data_out_q;
    product_d  = product_q;

    // Counter restarts on every state entry; idle does not count.
    if ((state_d != state_q) || (state_q == StIdle)) begin
      cnt_d = '0;
    end

    if ((state_q == StIdle) && req) begin
      b_d = b;
    end

    // The multiplicand goes straight from the input since it is only needed in the cycle
    // right after acceptance.
    if (state_d == StLoadM) begin
      data_out_d = a;
    end else if (state_d == StLoadQ) begin
      data_out_d = b_q;
    end

    if ((state_q == StReadLo) && last_read_cycle) begin
      product_d[n-1:0] = data;
    end
    if ((state_q == StReadHi) && last_read_cycle) begin
      product_d[2*n-1:n] = data;
    end

    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StFinish);
    err_d   = timeout_hit;
    start_d = (state_d == StStart);
    oe_d    = (state_d == StReadLo) || (state_d == StReadHi);
    drive_d = (state_d == StLoadM) || (state_d == StLoadQ);
    func_d  = func_for(state_d);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      b_q        <= '0;
      data_out_q <= '0;
      drive_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      oe_q       <= 1'b0;
      func_q     <= FuncReadLo;
      product_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      b_q        <= b_d;
      data_out_q <= data_out_d;
      drive_q    <= drive_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      start_q    <= start_d;
      oe_q       <= oe_d;
      func_q     <= func_d;
      product_q  <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign start   = start_q;
  assign oe      = oe_q;
  assign func    = func_q;
  assign product = product_q;

  // drive_q and oe_q are decoded from disjoint state sets, so the bus is never driven
  // while the multiplier's outputs are enabled.
  assign data = drive_q ? data_out_q : {n{1'bz}};

endmodule

// File: tb/tb_mult_driver.sv
// Testbench for mult_driver with a behavioural bus multiplier attached.
module tb_mult_driver;

  localparam int N       = 8;
  localparam int HOLD    = 4;
  localparam int TIMEOUT = 50;
  localparam int DEB     = 2;   // multiplier debounce on start
  localparam int LOW     = 10;  // cycles the multiplier keeps ready low while computing

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           req   = 1'b0;
  logic [N-1:0]   a     = '0;
  logic [N-1:0]   b     = '0;
  logic           busy, done, err, oe, start, ready;
  logic [1:0]     func;
  logic [2*N-1:0] product;
  wire  [N-1:0]   data;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  mult_driver #(
    .n      (N),
    .HOLD   (HOLD),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .product(product),
    .func   (func),
    .oe     (oe),
    .start  (start),
    .ready  (ready),
    .data   (data)
  );

  // Behavioural multiplier: latches operands on load codes, computes after a debounced
  // start pulse, drops ready while busy, then presents halves of the product on oe.
  logic [N-1:0]   m_reg   = '0;
  logic [N-1:0]   q_reg   = '0;
  logic [2*N-1:0] p_reg   = '0;
  int             start_run = 0;
  int             low_left  = 0;
  logic           ready_m = 1'b1;
  logic           stuck   = 1'b0;

  always @(posedge clock) begin
    if (func == 2'b00) m_reg <= data;
    if (func == 2'b01) q_reg <= data;
    if (start) begin
      start_run <= start_run + 1;
    end else begin
      start_run <= 0;
      if (start_run >= DEB && !stuck) begin
        p_reg    <= {{N{1'b0}}, m_reg} * {{N{1'b0}}, q_reg};
        ready_m  <= 1'b0;
        low_left <= LOW;
      end
    end
    if (!ready_m && low_left > 0) begin
      low_left <= low_left - 1;
      if (low_left == 1) ready_m <= 1'b1;
    end
  end

  assign ready = stuck ? 1'b1 : ready_m;
  assign data  = oe ? ((func == 2'b11) ? p_reg[2*N-1:N] : p_reg[N-1:0]) : {N{1'bz}};

  // Bus monitor: cumulative counters, read as deltas by the stimulus.
  int         starts = 0;
  int         oes    = 0;
  int         dones  = 0;
  int         viol   = 0;
  logic [9:0] load_log[$];

  always @(negedge clock) begin
    if (reset) begin
      if (func == 2'b00 || func == 2'b01) load_log.push_back({func, data});
      if (start) starts <= starts + 1;
      if (oe) oes <= oes + 1;
      if (done) dones <= dones + 1;
      if ((oe && !func[1]) || (oe && dut.drive_q) || (!func[1] && !dut.drive_q))
        viol <= viol + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_txn(input logic [N-1:0] av, input logic [N-1:0] bv, input bit expect_to,
                        input bit noisy);
    int s0, o0, d0, l0, v0, lat, pa;
    logic [2*N-1:0] prev;
    bit seen;
    prev = product;
    pa   = int'(av) * int'(bv);
    s0 = starts; o0 = oes; d0 = dones; l0 = load_log.size(); v0 = viol;
    @(negedge clock);
    a = av; b = bv; req = 1'b1;
    @(negedge clock);
    req = 1'b0; a = N'($urandom); b = N'($urandom);
    chk("busy_after_req", busy, 1);
    seen = 0; lat = 0;
    for (int i = 1; i <= 300 && !seen; i++) begin
      @(negedge clock);
      if (done) begin
        seen = 1; lat = i; req = 1'b0;
      end else if (noisy && $urandom_range(0, 3) == 0) begin
        req = 1'b1; a = N'($urandom); b = N'($urandom);
      end else begin
        req = 1'b0;
      end
    end
    req = 1'b0;
    chk("done_seen", 32'(seen), 1);
    chk("err", err, 32'(expect_to));
    if (expect_to) begin
      chk("product_kept", product, prev);
      chk("timeout_latency", lat, 2 + HOLD + TIMEOUT);
      chk("oe_cycles", oes - o0, 0);
    end else begin
      chk("product", product, pa & 32'hffff);
      chk("oe_cycles", oes - o0, 4);
    end
    chk("start_cycles", starts - s0, HOLD);
    chk("load_count", load_log.size() - l0, 2);
    if (load_log.size() - l0 == 2) begin
      chk("load_m", load_log[l0], {2'b00, av});
      chk("load_q", load_log[l0+1], {2'b01, bv});
    end
    chk("bus_protocol", viol - v0, 0);
    @(negedge clock);
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    chk("done_count", dones - d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    bit got;
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_start", start, 0);
    chk("rst_oe", oe, 0);
    chk("rst_func", func, 2'b10);
    chk("rst_product", product, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    do_txn(8'd13, 8'd11, 0, 0);
    chk("product_13x11", product, 16'h008f);
    do_txn(8'd255, 8'd255, 0, 1);
    chk("product_ff_ff", product, 16'hfe01);
    do_txn(8'd0, 8'd200, 0, 1);
    chk("product_0x200", product, 16'h0000);
    for (int k = 0; k < 5; k++) do_txn(N'($urandom), N'($urandom), 0, 1);

    @(negedge clock);
    stuck = 1'b1;
    do_txn(N'($urandom), N'($urandom), 1, 1);
    stuck = 1'b0;
    repeat (4) @(negedge clock);

    // Reset in the middle of WAIT_HI.
    @(negedge clock);
    a = 8'd77; b = 8'd99; req = 1'b1;
    @(negedge clock);
    req = 1'b0;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clock);
      if (!ready) got = 1;
    end
    chk("ready_dropped", 32'(got), 1);
    repeat (4) @(negedge clock);
    chk("in_flight_busy", busy, 1);
    d0 = dones;
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    chk("arst_start", start, 0);
    chk("arst_oe", oe, 0);
    chk("arst_func", func, 2'b10);
    chk("arst_drive", dut.drive_q, 0);
    chk("arst_product", product, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    chk("no_done_after_reset", dones - d0, 0);
    do_txn(8'd3, 8'd5, 0, 0);
    chk("product_3x5", product, 16'h000f);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
